// File: rtl/vproc_burst_master.sv
// vproc_burst_master: command-driven VProc-style bus master with burst support.
// Commands arrive on a valid/ready port. Write beats arrive on a valid/ready stream.
// Read beats leave as single-cycle pulses and cannot be backpressured.
// Optional ack timeout: define VPROC_BUS_TIMEOUT_EN to enable it. Without it, Error is tied 0.
module vproc_burst_master #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BURST_WIDTH     = 12,
  parameter int unsigned BURST_ADDR_INCR = 1,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic                   Clk,
  input  logic                   nReset,
  input  logic                   CmdValid,
  output logic                   CmdReady,
  input  logic [ADDR_WIDTH-1:0]  CmdAddr,
  input  logic                   CmdWE,
  input  logic [BURST_WIDTH-1:0] CmdBurst,
  input  logic [DATA_WIDTH-1:0]  WrData,
  input  logic                   WrDataValid,
  output logic                   WrDataReady,
  output logic [DATA_WIDTH-1:0]  RdData,
  output logic                   RdDataValid,
  output logic                   RdDataLast,
  output logic [ADDR_WIDTH-1:0]  Addr,
  output logic                   WE,
  output logic                   RD,
  output logic [DATA_WIDTH-1:0]  DataOut,
  input  logic [DATA_WIDTH-1:0]  DataIn,
  input  logic                   WRAck,
  input  logic                   RDAck,
  output logic [BURST_WIDTH-1:0] Burst,
  output logic                   BurstFirst,
  output logic                   BurstLast,
  output logic                   Error
);

  typedef enum logic [1:0] {StIdle, StWrData, StWrAcc, StRdAcc} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  dataout_q, dataout_d;
  logic [DATA_WIDTH-1:0]  rddata_q, rddata_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic [BURST_WIDTH-1:0] remain_q, remain_d;
  logic                   we_q, we_d, rd_q, rd_d;
  logic                   first_q, first_d, last_q, last_d;
  logic                   rdvalid_q, rdvalid_d, rdlast_q, rdlast_d;
  logic                   final_beat;
  logic                   timeout;

  assign final_beat = (remain_q == BURST_WIDTH'(1));

`ifdef VPROC_BUS_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          waiting;
  logic          error_q;

  // A strobe is outstanding and this cycle brought no matching ack.
  assign waiting = ((state_q == StWrAcc) && !WRAck) || ((state_q == StRdAcc) && !RDAck);
  assign timeout = waiting && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign Error   = error_q;

  // Per-beat wait counter: cleared outside the ack states and on every ack.
  always_comb begin
    tcnt_d = '0;
    if (waiting) tcnt_d = tcnt_q + TW'(1);
  end

  // Timeout counter and single-cycle Error pulse.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      tcnt_q  <= '0;
      error_q <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      error_q <= timeout;
    end
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign Error   = 1'b0;
`endif

  // State register and registered bus-side outputs.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      dataout_q <= '0;
      rddata_q  <= '0;
      burst_q   <= '0;
      remain_q  <= '0;
      we_q      <= 1'b0;
      rd_q      <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      rdvalid_q <= 1'b0;
      rdlast_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      dataout_q <= dataout_d;
      rddata_q  <= rddata_d;
      burst_q   <= burst_d;
      remain_q  <= remain_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      first_q   <= first_d;
      last_q    <= last_d;
      rdvalid_q <= rdvalid_d;
      rdlast_q  <= rdlast_d;
    end
  end

  // Next-state and next-output decode for the command/beat sequencer.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dataout_d = dataout_q;
    rddata_d  = rddata_q;
    burst_d   = burst_q;
    remain_d  = remain_q;
    we_d      = we_q;
    rd_d      = rd_q;
    first_d   = first_q;
    last_d    = last_q;
    rdvalid_d = 1'b0;
    rdlast_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (CmdValid) begin
          addr_d   = CmdAddr;
          burst_d  = CmdBurst;
          remain_d = (CmdBurst == '0) ? BURST_WIDTH'(1) : CmdBurst;
          first_d  = (CmdBurst != '0);
          last_d   = (CmdBurst == BURST_WIDTH'(1));
          if (CmdWE) begin
            state_d = StWrData;
          end else begin
            rd_d    = 1'b1;
            state_d = StRdAcc;
          end
        end
      end
      StWrData: begin
        if (WrDataValid) begin
          dataout_d = WrData;
          we_d      = 1'b1;
          state_d   = StWrAcc;
        end
      end
      StWrAcc: begin
        if (WRAck) begin
          remain_d = remain_q - BURST_WIDTH'(1);
          if (final_beat) begin
            we_d    = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
            burst_d = '0;
            state_d = StIdle;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(BURST_ADDR_INCR);
            first_d = 1'b0;
            last_d  = (remain_q == BURST_WIDTH'(2));
            // Data already waiting keeps WE asserted across the beat boundary.
            if (WrDataValid) begin
              dataout_d = WrData;
            end else begin
              we_d    = 1'b0;
              state_d = StWrData;
            end
          end
        end else if (timeout) begin
          we_d     = 1'b0;
          first_d  = 1'b0;
          last_d   = 1'b0;
          burst_d  = '0;
          remain_d = '0;
          state_d  = StIdle;
        end
      end
      StRdAcc: begin
        if (RDAck) begin
          rddata_d  = DataIn;
          rdvalid_d = 1'b1;
          rdlast_d  = final_beat;
          remain_d  = remain_q - BURST_WIDTH'(1);
          if (final_beat) begin
            rd_d    = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
            burst_d = '0;
            state_d = StIdle;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(BURST_ADDR_INCR);
            first_d = 1'b0;
            last_d  = (remain_q == BURST_WIDTH'(2));
          end
        end else if (timeout) begin
          rd_d     = 1'b0;
          first_d  = 1'b0;
          last_d   = 1'b0;
          burst_d  = '0;
          remain_d = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded directly from state and the current ack.
  always_comb begin
    CmdReady    = (state_q == StIdle);
    WrDataReady = (state_q == StWrData) ||
                  ((state_q == StWrAcc) && WRAck && (remain_q > BURST_WIDTH'(1)));
  end

  assign Addr        = addr_q;
  assign WE          = we_q;
  assign RD          = rd_q;
  assign DataOut     = dataout_q;
  assign Burst       = burst_q;
  assign BurstFirst  = first_q;
  assign BurstLast   = last_q;
  assign RdData      = rddata_q;
  assign RdDataValid = rdvalid_q;
  assign RdDataLast  = rdlast_q;

endmodule
